// File: rtl/rab_txn_forward.sv
// Address-channel forwarding stage behind the RAB translation FSM: issues one
// master AXI address beat or one error-response request per decision, then pulses sent.
module rab_txn_forward #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8,
    parameter int ATTR_WIDTH = 24,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_areset,
    input  logic                  port1_accept,
    input  logic                  port1_drop,
    input  logic                  port2_accept,
    input  logic                  port2_drop,
    input  logic [ADDR_WIDTH-1:0] out_addr_reg,
    input  logic [ID_WIDTH-1:0]   s1_id,
    input  logic [ID_WIDTH-1:0]   s2_id,
    input  logic [ATTR_WIDTH-1:0] s1_attr,
    input  logic [ATTR_WIDTH-1:0] s2_attr,
    output logic                  port1_sent,
    output logic                  port2_sent,
    output logic [ADDR_WIDTH-1:0] m_axi_addr,
    output logic [ID_WIDTH-1:0]   m_axi_id,
    output logic [ATTR_WIDTH-1:0] m_axi_attr,
    output logic                  m_axi_valid,
    input  logic                  m_axi_ready,
    output logic                  drop_valid,
    output logic [ID_WIDTH-1:0]   drop_id,
    output logic [ATTR_WIDTH-1:0] drop_attr,
    output logic                  drop_port,
    input  logic                  drop_ready,
    output logic [CNT_WIDTH-1:0]  drop_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic [ID_WIDTH-1:0]   m_id_q, m_id_d;
    logic [ATTR_WIDTH-1:0] m_attr_q, m_attr_d;
    logic                  m_valid_q, m_valid_d;
    logic                  fwd_port_q, fwd_port_d;
    logic                  drop_valid_q, drop_valid_d;
    logic [ID_WIDTH-1:0]   drop_id_q, drop_id_d;
    logic [ATTR_WIDTH-1:0] drop_attr_q, drop_attr_d;
    logic                  drop_port_q, drop_port_d;
    logic                  sent1_q, sent1_d;
    logic                  sent2_q, sent2_d;
    logic [CNT_WIDTH-1:0]  drop_count_q, drop_count_d;

    always_comb begin
        state_d      = state_q;
        m_addr_d     = m_addr_q;
        m_id_d       = m_id_q;
        m_attr_d     = m_attr_q;
        m_valid_d    = m_valid_q;
        fwd_port_d   = fwd_port_q;
        drop_valid_d = drop_valid_q;
        drop_id_d    = drop_id_q;
        drop_attr_d  = drop_attr_q;
        drop_port_d  = drop_port_q;
        drop_count_d = drop_count_q;
        sent1_d      = 1'b0;
        sent2_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // Coinciding pulses: port1 before port2, accept before drop.
                if (port1_accept) begin
                    state_d    = FWD;
                    m_valid_d  = 1'b1;
                    m_addr_d   = out_addr_reg;
                    m_id_d     = s1_id;
                    m_attr_d   = s1_attr;
                    fwd_port_d = 1'b0;
                end else if (port1_drop) begin
                    state_d      = DROP;
                    drop_valid_d = 1'b1;
                    drop_id_d    = s1_id;
                    drop_attr_d  = s1_attr;
                    drop_port_d  = 1'b0;
                end else if (port2_accept) begin
                    state_d    = FWD;
                    m_valid_d  = 1'b1;
                    m_addr_d   = out_addr_reg;
                    m_id_d     = s2_id;
                    m_attr_d   = s2_attr;
                    fwd_port_d = 1'b1;
                end else if (port2_drop) begin
                    state_d      = DROP;
                    drop_valid_d = 1'b1;
                    drop_id_d    = s2_id;
                    drop_attr_d  = s2_attr;
                    drop_port_d  = 1'b1;
                end
            end
            FWD: begin
                if (m_valid_q && m_axi_ready) begin
                    state_d   = IDLE;
                    m_valid_d = 1'b0;
                    sent1_d   = ~fwd_port_q;
                    sent2_d   = fwd_port_q;
                end
            end
            DROP: begin
                if (drop_valid_q && drop_ready) begin
                    state_d      = IDLE;
                    drop_valid_d = 1'b0;
                    sent1_d      = ~drop_port_q;
                    sent2_d      = drop_port_q;
                    if (drop_count_q != {CNT_WIDTH{1'b1}}) begin
                        drop_count_d = drop_count_q + CNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            state_q      <= IDLE;
            m_addr_q     <= '0;
            m_id_q       <= '0;
            m_attr_q     <= '0;
            m_valid_q    <= 1'b0;
            fwd_port_q   <= 1'b0;
            drop_valid_q <= 1'b0;
            drop_id_q    <= '0;
            drop_attr_q  <= '0;
            drop_port_q  <= 1'b0;
            sent1_q      <= 1'b0;
            sent2_q      <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            m_addr_q     <= m_addr_d;
            m_id_q       <= m_id_d;
            m_attr_q     <= m_attr_d;
            m_valid_q    <= m_valid_d;
            fwd_port_q   <= fwd_port_d;
            drop_valid_q <= drop_valid_d;
            drop_id_q    <= drop_id_d;
            drop_attr_q  <= drop_attr_d;
            drop_port_q  <= drop_port_d;
            sent1_q      <= sent1_d;
            sent2_q      <= sent2_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign m_axi_addr  = m_addr_q;
    assign m_axi_id    = m_id_q;
    assign m_axi_attr  = m_attr_q;
    assign m_axi_valid = m_valid_q;
    assign drop_valid  = drop_valid_q;
    assign drop_id     = drop_id_q;
    assign drop_attr   = drop_attr_q;
    assign drop_port   = drop_port_q;
    assign port1_sent  = sent1_q;
    assign port2_sent  = sent2_q;
    assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_rab_txn_forward.sv
// Directed bench for rab_txn_forward: inputs change and outputs are sampled on
// the falling edge, so each tick is one DUT cycle.
module tb_rab_txn_forward;

    localparam int AW = 32;
    localparam int IW = 8;
    localparam int TW = 24;
    // Narrow counter so saturation is reachable in a few hundred drops.
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          p1_acc, p1_drop, p2_acc, p2_drop;
    logic [AW-1:0] addr_in;
    logic [IW-1:0] s1_id, s2_id;
    logic [TW-1:0] s1_attr, s2_attr;
    logic          p1_sent, p2_sent;
    logic [AW-1:0] m_addr;
    logic [IW-1:0] m_id;
    logic [TW-1:0] m_attr;
    logic          m_valid, m_ready;
    logic          d_valid, d_port, d_ready;
    logic [IW-1:0] d_id;
    logic [TW-1:0] d_attr;
    logic [CW-1:0] d_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    rab_txn_forward #(
        .ADDR_WIDTH(AW), .ID_WIDTH(IW), .ATTR_WIDTH(TW), .CNT_WIDTH(CW)
    ) dut (
        .s_axi_aclk  (clk),
        .s_axi_areset(rst),
        .port1_accept(p1_acc),
        .port1_drop  (p1_drop),
        .port2_accept(p2_acc),
        .port2_drop  (p2_drop),
        .out_addr_reg(addr_in),
        .s1_id       (s1_id),
        .s2_id       (s2_id),
        .s1_attr     (s1_attr),
        .s2_attr     (s2_attr),
        .port1_sent  (p1_sent),
        .port2_sent  (p2_sent),
        .m_axi_addr  (m_addr),
        .m_axi_id    (m_id),
        .m_axi_attr  (m_attr),
        .m_axi_valid (m_valid),
        .m_axi_ready (m_ready),
        .drop_valid  (d_valid),
        .drop_id     (d_id),
        .drop_attr   (d_attr),
        .drop_port   (d_port),
        .drop_ready  (d_ready),
        .drop_count  (d_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("check %-16s observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One full drop with drop_ready already high: pulse, request, sent.
    task automatic do_drop(input logic port2);
        p1_drop = ~port2;
        p2_drop = port2;
        tick();
        p1_drop = 1'b0;
        p2_drop = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        {p1_acc, p1_drop, p2_acc, p2_drop} = 4'b0;
        addr_in = '0; s1_id = '0; s2_id = '0; s1_attr = '0; s2_attr = '0;
        m_ready = 1'b0; d_ready = 1'b0;
        tick();
        tick();
        chk("rst_mvalid", 64'(m_valid), 64'd0);
        chk("rst_dvalid", 64'(d_valid), 64'd0);
        chk("rst_sent", 64'({p1_sent, p2_sent}), 64'd0);
        chk("rst_count", 64'(d_count), 64'd0);
        chk("rst_addr", 64'(m_addr), 64'd0);
        rst = 1'b0;
        tick();

        // Port1 accept with ready already high: valid at N+1, sent at N+2.
        p1_acc = 1'b1; addr_in = 32'h8000_1000; s1_id = 8'h03; s1_attr = 24'hA5A5A5;
        m_ready = 1'b1;
        tick();
        p1_acc = 1'b0; addr_in = 32'hDEAD_BEEF;
        chk("t1_valid", 64'(m_valid), 64'd1);
        chk("t1_addr", 64'(m_addr), 64'h8000_1000);
        chk("t1_id", 64'(m_id), 64'h3);
        chk("t1_attr", 64'(m_attr), 64'hA5A5A5);
        chk("t1_sent_early", 64'({p1_sent, p2_sent}), 64'd0);
        tick();
        chk("t1_valid_off", 64'(m_valid), 64'd0);
        chk("t1_sent", 64'({p1_sent, p2_sent}), 64'b10);
        tick();
        chk("t1_sent_pulse", 64'({p1_sent, p2_sent}), 64'd0);

        // Port2 accept with ready held low for five cycles.
        p2_acc = 1'b1; addr_in = 32'h1234_5678; s2_id = 8'h5C; s2_attr = 24'h00_0F_12;
        m_ready = 1'b0;
        tick();
        p2_acc = 1'b0; addr_in = '0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_valid", 64'(m_valid), 64'd1);
            chk("t2_addr", 64'(m_addr), 64'h1234_5678);
            chk("t2_id", 64'(m_id), 64'h5C);
            chk("t2_nosent", 64'({p1_sent, p2_sent}), 64'd0);
            tick();
        end
        m_ready = 1'b1;
        chk("t2_valid6", 64'(m_valid), 64'd1);
        chk("t2_attr", 64'(m_attr), 64'h000F12);
        tick();
        m_ready = 1'b0;
        chk("t2_valid_off", 64'(m_valid), 64'd0);
        chk("t2_sent", 64'({p1_sent, p2_sent}), 64'b01);
        tick();
        chk("t2_sent_pulse", 64'({p1_sent, p2_sent}), 64'd0);

        // Port1 drop, error generator ready after three cycles.
        p1_drop = 1'b1; s1_id = 8'h07; s1_attr = 24'h00_00_0F;
        tick();
        p1_drop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t3_dvalid", 64'(d_valid), 64'd1);
            chk("t3_did", 64'(d_id), 64'h7);
            chk("t3_dport", 64'(d_port), 64'd0);
            chk("t3_mvalid", 64'(m_valid), 64'd0);
            tick();
        end
        d_ready = 1'b1;
        chk("t3_dattr", 64'(d_attr), 64'h00000F);
        tick();
        chk("t3_dvalid_off", 64'(d_valid), 64'd0);
        chk("t3_sent", 64'({p1_sent, p2_sent}), 64'b10);
        chk("t3_count", 64'(d_count), 64'd1);
        chk("t3_mvalid_off", 64'(m_valid), 64'd0);
        tick();

        // Both ports accept together: only port1 is forwarded.
        p1_acc = 1'b1; p2_acc = 1'b1; s1_id = 8'h11; s2_id = 8'h22;
        addr_in = 32'h0000_4000; m_ready = 1'b1;
        tick();
        p1_acc = 1'b0; p2_acc = 1'b0;
        chk("t4_valid", 64'(m_valid), 64'd1);
        chk("t4_id", 64'(m_id), 64'h11);
        tick();
        chk("t4_sent", 64'({p1_sent, p2_sent}), 64'b10);
        tick();
        chk("t4_no_p2", 64'({p1_sent, p2_sent}), 64'd0);
        chk("t4_idle", 64'(m_valid), 64'd0);

        // Port2 drop lands on port 1 of the error generator.
        p2_drop = 1'b1; s2_id = 8'h9A;
        tick();
        p2_drop = 1'b0;
        chk("t5_dport", 64'(d_port), 64'd1);
        chk("t5_did", 64'(d_id), 64'h9A);
        tick();
        chk("t5_sent", 64'({p1_sent, p2_sent}), 64'b01);
        chk("t5_count", 64'(d_count), 64'd2);
        tick();

        // Fill the counter to all-ones-minus-one, then saturate.
        for (int i = 0; i < 252; i++) do_drop(i[0]);
        chk("sat_pre", 64'(d_count), 64'hFE);
        for (int i = 0; i < 3; i++) begin
            do_drop(1'b0);
            chk("sat_hold", 64'(d_count), 64'hFF);
        end

        // Reset in FWD with ready low abandons the transaction.
        p1_acc = 1'b1; addr_in = 32'hCAFE_0000; s1_id = 8'h42; m_ready = 1'b0;
        tick();
        p1_acc = 1'b0;
        chk("t6_valid", 64'(m_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(m_valid), 64'd0);
        chk("t6_rst_addr", 64'(m_addr), 64'd0);
        chk("t6_rst_id", 64'(m_id), 64'd0);
        chk("t6_rst_count", 64'(d_count), 64'd0);
        tick();
        rst = 1'b0;
        m_ready = 1'b1;
        tick();
        chk("t6_nosent", 64'({p1_sent, p2_sent, m_valid}), 64'd0);
        p1_acc = 1'b1; addr_in = 32'h0BAD_F00D; s1_id = 8'h21;
        tick();
        p1_acc = 1'b0;
        chk("t6_fresh_valid", 64'(m_valid), 64'd1);
        chk("t6_fresh_addr", 64'(m_addr), 64'h0BAD_F00D);
        tick();
        chk("t6_fresh_sent", 64'({p1_sent, p2_sent}), 64'b10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
